// File: rtl/increment_term_pkg.sv
// Shared state encoding, arithmetic widths and the wrap/saturate adder for the increment-term engine.
// Optional feature macro: TERM_SATURATE_EN (saturating arithmetic instead of wrap-around).
package increment_term_pkg;

    localparam int unsigned STATE_W = 3;
    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S_IDLE = 3'd0;
    localparam state_t S_LOAD = 3'd1;
    localparam state_t S_FILL = 3'd2;
    localparam state_t S_WAIT = 3'd3;
    localparam state_t S_STEP = 3'd4;

    // Wide enough that a sum of two sign-extended term values never overflows.
    localparam int unsigned CALC_W = 64;
    typedef logic signed [CALC_W-1:0] calc_t;

    // Adds two w-bit values carried sign-extended; result is reduced back into w-bit range.
    function automatic calc_t term_add(input calc_t a, input calc_t b, input int unsigned w);
        calc_t sum;
        sum = a + b;
`ifdef TERM_SATURATE_EN
        begin
            calc_t hi;
            calc_t lo;
            hi = (calc_t'(1) <<< (w - 1)) - calc_t'(1);
            lo = -(calc_t'(1) <<< (w - 1));
            if (sum > hi) begin
                sum = hi;
            end else if (sum < lo) begin
                sum = lo;
            end
        end
`else
        sum = (sum <<< (CALC_W - w)) >>> (CALC_W - w);
`endif
        return sum;
    endfunction

endpackage

// File: rtl/increment_term_engine_if.sv
// Control/data bundle between a scan controller (master) and the increment-term engine (slave).
interface increment_term_engine_if #(
    parameter int unsigned DW_INTEGER   = 16,
    parameter int unsigned DW_FRACTION  = 8,
    parameter int unsigned DW_OUT_DROP  = 4,
    parameter int unsigned NUM_ELEMENTS = 64,
    parameter int unsigned DW_STEP      = 4
);
    localparam int unsigned W  = DW_INTEGER + DW_FRACTION + 1;
    localparam int unsigned OW = DW_INTEGER + DW_FRACTION - DW_OUT_DROP + 1;

    logic                     configure;
    logic signed [W-1:0]      r0_term;
    logic signed [W-1:0]      cos_term;
    logic                     cos_valid;
    logic [DW_STEP-1:0]       step;
    logic                     ack;
    logic                     final_scanpoint;
    logic signed [OW-1:0]     output_terms [NUM_ELEMENTS];
    logic                     ready;
    logic                     done_configuring;
    logic                     step_err;

    modport master (
        output configure, r0_term, cos_term, cos_valid, step, ack, final_scanpoint,
        input  output_terms, ready, done_configuring, step_err
    );

    modport slave (
        input  configure, r0_term, cos_term, cos_valid, step, ack, final_scanpoint,
        output output_terms, ready, done_configuring, step_err
    );

endinterface

// File: rtl/increment_term_lane.sv
// One element's term register: clear, load from the fill network, or advance by the scan step.
module increment_term_lane
    import increment_term_pkg::*;
#(
    parameter int unsigned W = 25
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clear,
    input  logic                load,
    input  logic signed [W-1:0] load_val,
    input  logic                step_en,
    input  logic signed [W-1:0] step_inc,
    output logic signed [W-1:0] term
);

    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            term <= '0;
        end else if (load) begin
            term <= load_val;
        end else if (step_en) begin
            term <= W'(term_add(CALC_W'(term), CALC_W'(step_inc), W));
        end
    end

endmodule

// File: rtl/increment_term_engine.sv
// Builds T[e] = 1.0 + r0 - (e-(HALF-1))*cos outward from the centre by repeated add, then steps all terms.
// Optional feature macro: TERM_SATURATE_EN (saturate instead of wrap on every add/sub).
module increment_term_engine
    import increment_term_pkg::*;
#(
    parameter int unsigned DW_INTEGER   = 16,
    parameter int unsigned DW_FRACTION  = 8,
    parameter int unsigned DW_OUT_DROP  = 4,
    parameter int unsigned NUM_ELEMENTS = 64,
    parameter int unsigned LANES        = 1,
    parameter int unsigned DW_STEP      = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    increment_term_engine_if.slave bus
);

    localparam int unsigned W           = DW_INTEGER + DW_FRACTION + 1;
    localparam int unsigned HALF        = NUM_ELEMENTS / 2;
    localparam int unsigned CENTER      = HALF - 1;
    localparam int unsigned FILL_CYCLES = HALF / LANES;
    localparam int unsigned CNT_W       = $clog2(FILL_CYCLES + 1);
    localparam logic [CNT_W-1:0]   LAST_FILL = CNT_W'(FILL_CYCLES - 1);
    localparam logic signed [W-1:0] ONE      = W'(64'd1 << DW_FRACTION);

    state_t               state, state_d;
    logic [CNT_W-1:0]     fill_cnt, fill_cnt_d;
    logic signed [W-1:0]  r0_q, r0_d, cos_q, cos_d;
    logic [DW_STEP-1:0]   step_q, step_d;
    logic                 ready_q, ready_d, done_q, done_d, err_q, err_d;
    logic                 center_load, fill_en, clear_all, step_all;

    logic signed [W-1:0]  terms   [NUM_ELEMENTS];
    logic signed [W-1:0]  pos_val [LANES];
    logic signed [W-1:0]  neg_val [LANES];
    logic signed [W-1:0]  pos_base, neg_base, center_val, step_inc;

    assign center_val = W'(term_add(CALC_W'(r0_q), CALC_W'(ONE), W));
    assign step_inc   = W'({step_q, 1'b0}) << DW_FRACTION;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            fill_cnt <= '0;
            r0_q     <= '0;
            cos_q    <= '0;
            step_q   <= '0;
            ready_q  <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_d;
            fill_cnt <= fill_cnt_d;
            r0_q     <= r0_d;
            cos_q    <= cos_d;
            step_q   <= step_d;
            ready_q  <= ready_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d     = state;
        fill_cnt_d  = fill_cnt;
        r0_d        = r0_q;
        cos_d       = cos_q;
        step_d      = step_q;
        ready_d     = 1'b0;
        done_d      = done_q;
        err_d       = err_q;
        center_load = 1'b0;
        fill_en     = 1'b0;
        clear_all   = 1'b0;
        step_all    = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.configure) begin
                    if (bus.step == '0) begin
                        err_d = 1'b1;
                    end else begin
                        r0_d    = bus.r0_term;
                        step_d  = bus.step;
                        err_d   = 1'b0;
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (bus.cos_valid) begin
                    cos_d       = bus.cos_term;
                    center_load = 1'b1;
                    fill_cnt_d  = '0;
                    state_d     = S_FILL;
                end
            end
            S_FILL: begin
                fill_en = 1'b1;
                if (fill_cnt == LAST_FILL) begin
                    ready_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    fill_cnt_d = fill_cnt + CNT_W'(1);
                end
            end
            S_WAIT: begin
                ready_d = 1'b1;
                if (bus.ack) begin
                    ready_d = 1'b0;
                    if (bus.final_scanpoint) begin
                        clear_all = 1'b1;
                        done_d    = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_STEP;
                    end
                end
            end
            S_STEP: begin
                step_all = 1'b1;
                ready_d  = 1'b1;
                state_d  = S_WAIT;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Innermost already-written element on each side for the current fill cycle.
    always_comb begin
        pos_base = '0;
        neg_base = '0;
        for (int unsigned e = 0; e < NUM_ELEMENTS; e++) begin
            if (e == CENTER + 32'(fill_cnt) * LANES) pos_base = terms[e];
            if (e + 32'(fill_cnt) * LANES == CENTER) neg_base = terms[e];
        end
    end

    // Chained adders so lane j sees lane j-1's value within the same cycle.
    always_comb begin
        calc_t p_run;
        calc_t n_run;
        p_run = CALC_W'(pos_base);
        n_run = CALC_W'(neg_base);
        for (int unsigned j = 0; j < LANES; j++) begin
            p_run      = term_add(p_run, -CALC_W'(cos_q), W);
            n_run      = term_add(n_run, CALC_W'(cos_q), W);
            pos_val[j] = W'(p_run);
            neg_val[j] = W'(n_run);
        end
    end

    for (genvar e = 0; e < NUM_ELEMENTS; e++) begin : g_lane
        logic                load;
        logic signed [W-1:0] load_val;

        if (e == CENTER) begin : g_center
            assign load     = center_load;
            assign load_val = center_val;
        end else if (e > CENTER) begin : g_pos
            localparam int unsigned M = e - CENTER;
            assign load     = fill_en && (fill_cnt == CNT_W'((M - 1) / LANES));
            assign load_val = pos_val[(M - 1) % LANES];
        end else begin : g_neg
            localparam int unsigned K = CENTER - e;
            assign load     = fill_en && (fill_cnt == CNT_W'((K - 1) / LANES));
            assign load_val = neg_val[(K - 1) % LANES];
        end

        increment_term_lane #(.W(W)) u_lane (
            .clk      (clk),
            .rst      (rst),
            .clear    (clear_all),
            .load     (load),
            .load_val (load_val),
            .step_en  (step_all),
            .step_inc (step_inc),
            .term     (terms[e])
        );

        assign bus.output_terms[e] = terms[e][W-1:DW_OUT_DROP];
    end

    assign bus.ready            = ready_q;
    assign bus.done_configuring = done_q;
    assign bus.step_err         = err_q;

endmodule

// File: tb/tb_increment_term_engine.sv
// Drives a LANES=1 and a LANES=2 engine with identical stimulus and checks both against a term model.
module tb_increment_term_engine;

    localparam int unsigned DI   = 16;
    localparam int unsigned DF   = 8;
    localparam int unsigned DD   = 4;
    localparam int unsigned NE   = 8;
    localparam int unsigned DS   = 4;
    localparam int unsigned W    = DI + DF + 1;
    localparam int unsigned OW   = W - DD;
    localparam int unsigned HALF = NE / 2;
    localparam int unsigned NVEC = 13;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                configure, cos_valid, ack, final_scanpoint;
    logic signed [W-1:0] r0_term, cos_term;
    logic [DS-1:0]       step;

    increment_term_engine_if #(.DW_INTEGER(DI), .DW_FRACTION(DF), .DW_OUT_DROP(DD),
                               .NUM_ELEMENTS(NE), .DW_STEP(DS)) bus1 ();
    increment_term_engine_if #(.DW_INTEGER(DI), .DW_FRACTION(DF), .DW_OUT_DROP(DD),
                               .NUM_ELEMENTS(NE), .DW_STEP(DS)) bus2 ();

    assign bus1.configure = configure;       assign bus2.configure = configure;
    assign bus1.r0_term = r0_term;           assign bus2.r0_term = r0_term;
    assign bus1.cos_term = cos_term;         assign bus2.cos_term = cos_term;
    assign bus1.cos_valid = cos_valid;       assign bus2.cos_valid = cos_valid;
    assign bus1.step = step;                 assign bus2.step = step;
    assign bus1.ack = ack;                   assign bus2.ack = ack;
    assign bus1.final_scanpoint = final_scanpoint;
    assign bus2.final_scanpoint = final_scanpoint;

    increment_term_engine #(.DW_INTEGER(DI), .DW_FRACTION(DF), .DW_OUT_DROP(DD),
                            .NUM_ELEMENTS(NE), .LANES(1), .DW_STEP(DS))
        dut1 (.clk(clk), .rst(rst), .bus(bus1));
    increment_term_engine #(.DW_INTEGER(DI), .DW_FRACTION(DF), .DW_OUT_DROP(DD),
                            .NUM_ELEMENTS(NE), .LANES(2), .DW_STEP(DS))
        dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        logic signed [W-1:0]  r0;
        logic signed [W-1:0]  cos;
        logic [DS-1:0]        st;
        int                   nacks;
        int                   chk_e;
        logic signed [OW-1:0] chk_out;
    } vec_t;

    vec_t vecs [NVEC];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reduce an exact value to the engine's internal width (wrap or clamp).
    function automatic longint fixw(input longint v);
`ifdef TERM_SATURATE_EN
        longint hi = (longint'(1) << (W - 1)) - 1;
        longint lo = -(longint'(1) << (W - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        longint m = v & ((longint'(1) << W) - 1);
        if (m >= (longint'(1) << (W - 1))) m -= (longint'(1) << W);
        return m;
`endif
    endfunction

    // Term for element e: centre value, walked outward one cos per element, plus nacks scan steps.
    function automatic longint model_term(input int e, input longint r0, input longint cos,
                                          input int st, input int nacks);
        longint v = fixw((longint'(1) << DF) + r0);
        int c = int'(HALF) - 1;
        for (int i = 0; i < e - c; i++) v = fixw(v - cos);
        for (int i = 0; i < c - e; i++) v = fixw(v + cos);
        for (int k = 0; k < nacks; k++) v = fixw(v + (longint'(2 * st) << DF));
        return v;
    endfunction

    task automatic check_terms(input string name, input vec_t v);
        logic signed [OW-1:0] exp;
        for (int e = 0; e < int'(NE); e++) begin
            exp = OW'(model_term(e, longint'(v.r0), longint'(v.cos), int'(v.st), v.nacks) >>> DD);
            check($sformatf("%s_l1_t%0d", name, e), bus1.output_terms[e], exp);
            check($sformatf("%s_l2_t%0d", name, e), bus2.output_terms[e], exp);
        end
    endtask

    task automatic check_idle(input string name);
        for (int e = 0; e < int'(NE); e++) begin
            check($sformatf("%s_l1_t%0d", name, e), bus1.output_terms[e], 0);
            check($sformatf("%s_l2_t%0d", name, e), bus2.output_terms[e], 0);
        end
        check({name, "_ready"}, {bus1.ready, bus2.ready}, 0);
        check({name, "_done"}, {bus1.done_configuring, bus2.done_configuring}, 0);
    endtask

    task automatic start_config(input vec_t v);
        configure = 1'b1;
        r0_term   = v.r0;
        step      = v.st;
        tick();
        configure = 1'b0;
        r0_term   = '0;
        cos_valid = 1'b1;
        cos_term  = v.cos;
        tick();
        cos_valid = 1'b0;
        cos_term  = '0;
    endtask

    task automatic run_vector(input int idx, input vec_t v);
        int lat1 = 0;
        int lat2 = 0;
        string nm = $sformatf("v%0d", idx);
        start_config(v);
        for (int n = 1; n <= 20 && (lat1 == 0 || lat2 == 0); n++) begin
            if (lat1 == 0 && bus1.ready) lat1 = n;
            if (lat2 == 0 && bus2.ready) lat2 = n;
            if (lat1 == 0 || lat2 == 0) tick();
        end
        check({nm, "_latency_l1"}, lat1, 1 + HALF);
        check({nm, "_latency_l2"}, lat2, 1 + HALF / 2);
        check({nm, "_done"}, {bus1.done_configuring, bus2.done_configuring}, 2'b11);
        check({nm, "_step_err"}, {bus1.step_err, bus2.step_err}, 0);
        for (int k = 0; k < v.nacks; k++) begin
            ack = 1'b1;
            tick();
            ack = 1'b0;
            check($sformatf("%s_ack%0d_drop", nm, k), {bus1.ready, bus2.ready}, 0);
            tick();
            check($sformatf("%s_ack%0d_ready", nm, k), {bus1.ready, bus2.ready}, 2'b11);
        end
        if (v.chk_e >= 0) begin
            check({nm, "_const_l1"}, bus1.output_terms[v.chk_e], v.chk_out);
            check({nm, "_const_l2"}, bus2.output_terms[v.chk_e], v.chk_out);
        end
        check_terms(nm, v);
        ack             = 1'b1;
        final_scanpoint = 1'b1;
        tick();
        ack             = 1'b0;
        final_scanpoint = 1'b0;
        check_idle({nm, "_final"});
    endtask

    initial begin
        vec_t v;
        rst = 1'b0;
        configure = 1'b0; cos_valid = 1'b0; ack = 1'b0; final_scanpoint = 1'b0;
        r0_term = '0; cos_term = '0; step = '0;

        vecs[0] = '{25'sh000A00, 25'sh000180, 4'd1, 0, 3, 21'sh0000B0};
        vecs[1] = '{25'sh000A00, 25'sh000180, 4'd1, 0, 0, 21'sh0000F8};
        vecs[2] = '{25'sh000A00, 25'sh000180, 4'd3, 1, 3, 21'sh000110};
        vecs[3] = '{25'sh000A00, 25'sh000180, 4'd3, 1, 0, 21'sh000158};
        vecs[4] = '{25'sh000A00, 25'sh000180, 4'd1, 0, 7, 21'sh000050};
        vecs[5] = '{25'sh000A00, 25'sh000180, 4'd1, 0, 4, 21'sh000098};
        vecs[6] = '{25'sh0FFFFFF, 25'sh000000, 4'd7, 3, -1, '0};
        for (int i = 7; i < int'(NVEC); i++) begin
            vecs[i].r0      = W'($urandom);
            vecs[i].cos     = W'($urandom);
            vecs[i].st      = DS'($urandom_range(15, 1));
            vecs[i].nacks   = int'($urandom_range(3, 0));
            vecs[i].chk_e   = -1;
            vecs[i].chk_out = '0;
        end

        repeat (3) tick();
        check_idle("reset");
        check("reset_step_err", {bus1.step_err, bus2.step_err}, 0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < int'(NVEC); i++) run_vector(i, vecs[i]);

        // Reset during the second fill cycle, then a clean restart.
        v = vecs[2];
        start_config(v);
        tick();
        rst = 1'b0;
        tick();
        check_idle("midfill_rst");
        check("midfill_rst_step_err", {bus1.step_err, bus2.step_err}, 0);
        rst = 1'b1;
        tick();
        run_vector(100, v);

        // Zero stride is rejected and the engine stays idle.
        v = vecs[0];
        v.st = '0;
        start_config(v);
        check("zero_step_err", {bus1.step_err, bus2.step_err}, 2'b11);
        repeat (6) tick();
        check_idle("zero_step_idle");
        check("zero_step_err_hold", {bus1.step_err, bus2.step_err}, 2'b11);
        rst = 1'b0;
        tick();
        check("zero_step_err_rst", {bus1.step_err, bus2.step_err}, 0);
        rst = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/increment_term_engine.md
INCREMENT_TERM_ENGINE -- requirements
Module: increment_term_engine

Interface
REQ-001 SHALL have parameter DW_INTEGER, default 16, integer bits of internal term.
REQ-002 SHALL have parameter DW_FRACTION, default 8, fraction bits of internal term and inputs.
REQ-003 SHALL have parameter DW_OUT_DROP, default 4, LSBs dropped at output.
REQ-004 SHALL have parameter NUM_ELEMENTS, default 64, even, >=4; HALF = NUM_ELEMENTS/2.
REQ-005 SHALL have parameter LANES, default 1, power of two dividing HALF; elements filled per side per cycle.
REQ-006 SHALL have parameter DW_STEP, default 4, width of point stride.
REQ-007 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-008 SHALL have port rst  in  1  reset, synchronous, active-low.
REQ-009 SHALL have ports configure in 1 (start), r0_term in DW_INTEGER+DW_FRACTION+1 signed (2*R0*fs/vs), cos_term in same width signed (2*p*fs/vs*cos), cos_valid in 1, step in DW_STEP unsigned (stride D), ack in 1, final_scanpoint in 1.
REQ-010 SHALL have ports output_terms out [NUM_ELEMENTS] x (DW_INTEGER+DW_FRACTION-DW_OUT_DROP+1) signed, ready out 1, done_configuring out 1, step_err out 1.

Function
REQ-011 SHALL implement FSM IDLE, LOAD, FILL, WAIT, STEP.
REQ-012 IDLE: configure=1 -> LOAD; capture r0_term and step; configure ignored in every other state.
REQ-013 LOAD: wait for cos_valid=1; on it capture cos_term, write center term T[HALF-1] = 1.0 + r0_term, -> FILL.
REQ-014 Target: T[e] = 1.0 + r0_term - (e-(HALF-1))*cos_term, e = 0..NUM_ELEMENTS-1.
REQ-015 FILL cycle c (1..HALF/LANES) SHALL write offsets m = (c-1)*LANES+1..c*LANES and m = -((c-1)*LANES+1)..-(c*LANES), clipped at -(HALF-1), each by adding or subtracting cos_term from the inner neighbour lane; no multipliers.
REQ-016 After final FILL cycle: ready=1, done_configuring=1, -> WAIT; config latency from cos_valid = 1+HALF/LANES cycles.
REQ-017 WAIT: ack & final_scanpoint -> IDLE; ack alone -> STEP; ready drops the cycle after ack.
REQ-018 STEP: every T[e] += 2*step (integer units), -> WAIT with ready=1; ack-to-ready = 2 cycles.
REQ-019 step=0 at configure: step_err=1 until next IDLE entry, block stays IDLE.
REQ-020 ready SHALL only be 1 in WAIT.
REQ-021 output_terms[e] = T[e][DW_INTEGER+DW_FRACTION:DW_OUT_DROP], registered, no truncation rounding.
REQ-022 Arithmetic SHALL be two's complement at DW_INTEGER+DW_FRACTION+1 bits.

Reset
REQ-023 rst=0 SHALL force IDLE, all T=0, ready=0, done_configuring=0, step_err=0, captured inputs=0, including mid-FILL or mid-STEP.
REQ-024 Entering IDLE from WAIT SHALL clear T, ready, done_configuring.

Configuration
REQ-025 With TERM_SATURATE_EN defined, every add/sub SHALL saturate to the signed max/min of the internal width.
REQ-026 Without TERM_SATURATE_EN, arithmetic SHALL wrap modulo 2^(DW_INTEGER+DW_FRACTION+1).

Structure
REQ-027 Package increment_term_pkg SHALL hold FSM state enum, width localparams and the saturating add function.
REQ-028 Sub-module increment_term_lane SHALL hold one term register with load/add/step/clear and the REQ-025/026 arithmetic; instantiated NUM_ELEMENTS times.

Verification
REQ-029 NUM_ELEMENTS=8, LANES=1, r0_term=0x0A00 (10.0), cos_term=0x0180 (1.5), step=1 -> after 5 cycles ready=1; T[3]=11.0 (out 0x0B0), T[4]=9.5, T[7]=5.0, T[0]=15.5.
REQ-030 Same, step=3, ack once -> 2 cycles later ready=1, T[3]=17.0, T[0]=21.5.
REQ-031 LANES=2, NUM_ELEMENTS=8, same inputs -> ready after 3 cycles, identical T as REQ-029.
REQ-032 ack with final_scanpoint=1 -> IDLE next cycle, all outputs 0, ready=0, done_configuring=0.
REQ-033 rst=0 asserted in 2nd FILL cycle -> next cycle IDLE, all outputs 0; configure then restarts cleanly.
REQ-034 r0_term=max positive, step=7, repeated acks -> clamp at max with TERM_SATURATE_EN, wrap negative without.
